// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG collector: FSM states, von Neumann pair codes, counter sizing.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL,
    FAIL
  } state_t;

  // Pair codes as {first, second}; only the unequal pairs produce a bit.
  localparam logic [1:0] VN_PAIR_01 = 2'b01;
  localparam logic [1:0] VN_PAIR_10 = 2'b10;

  // Width needed to hold values 0..n inclusive for power-of-two n.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/trng_collector_if.sv
// Word output stream of the TRNG collector: valid/ready, data held while valid && !ready.
interface trng_collector_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_vn_corrector.sv
// Von Neumann debiaser: pairs raw samples, emits a bit on the second sample of an unequal pair.
// Emit is combinational from the held first sample and the live raw bit; clr forces pair phase 0.
module trng_vn_corrector import trng_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic raw,
  output logic emit,
  output logic bit_out
);

  logic       phase;
  logic       b0;
  logic [1:0] pair;

  assign pair    = {b0, raw};
  assign emit    = en && phase && ((pair == VN_PAIR_01) || (pair == VN_PAIR_10));
  assign bit_out = (pair == VN_PAIR_10);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= 1'b0;
      b0    <= 1'b0;
    end else if (en) begin
      if (!phase) begin
        b0 <= raw;
      end
      phase <= ~phase;
    end
  end

endmodule

// File: rtl/trng_collector.sv
// TRNG collector: warmup, von Neumann correction, word packing; word valid 1 cycle after its bit count fills.
// Stalls sampling in FULL while the output word is unread. Macro TRNG_HEALTH_EN adds the repetition-count test.
module trng_collector import trng_pkg::*; #(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 16,
  parameter int RCT_CUTOFF    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    trng_en,
  input  logic                    trng_bit,
  trng_collector_if.master        rng,
  output logic                    health_fail,
  input  logic                    clear_fail
);

  localparam int CNT_W = cnt_width(WORD_WIDTH);
  localparam int WU_W  = cnt_width(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);

  state_t                state;
  logic [WU_W-1:0]       warm_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] shift;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  valid_q;

  logic vn_clr, vn_en, vn_emit, vn_bit;
  logic word_done, can_load, accept, fail_trip;

  assign rng.data  = data_q;
  assign rng.valid = valid_q;

  assign accept    = valid_q && rng.ready;
  assign can_load  = !valid_q || rng.ready;
  assign word_done = (bit_cnt == CNT_FULL);

  // Pair phase restarts at 0 whenever collection (re)starts; no sample is consumed on a stalled completion.
  assign vn_clr = (state != COLLECT);
  assign vn_en  = enable && (state == COLLECT) && (!word_done || can_load);

  trng_vn_corrector u_vn (
    .clk     (clk),
    .rst     (rst),
    .clr     (vn_clr),
    .en      (vn_en),
    .raw     (trng_bit),
    .emit    (vn_emit),
    .bit_out (vn_bit)
  );

`ifdef TRNG_HEALTH_EN
  localparam int REP_W = cnt_width(RCT_CUTOFF);
  localparam logic [REP_W-1:0] REP_CUT = REP_W'(RCT_CUTOFF);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             prev_bit;

  // rep_cnt == 0 marks the first sample after COLLECT entry.
  always_comb begin
    rep_next = REP_W'(1);
    if ((rep_cnt != '0) && (trng_bit == prev_bit)) begin
      rep_next = rep_cnt + REP_W'(1);
    end
  end

  assign fail_trip = enable && (state == COLLECT) && (rep_next == REP_CUT) && !clear_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt     <= '0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (state == COLLECT) begin
        rep_cnt  <= rep_next;
        prev_bit <= trng_bit;
      end else begin
        rep_cnt <= '0;
      end
      if (clear_fail) begin
        health_fail <= 1'b0;
      end else if (fail_trip) begin
        health_fail <= 1'b1;
      end
    end
  end
`else
  localparam int unused_rct_cutoff = RCT_CUTOFF;
  logic unused_clear_fail;

  assign unused_clear_fail = clear_fail;
  assign fail_trip         = 1'b0;
  assign health_fail       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      trng_en  <= 1'b0;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state    <= WARMUP;
            trng_en  <= 1'b1;
            warm_cnt <= '0;
          end
        end

        WARMUP: begin
          if (!enable) begin
            state   <= IDLE;
            trng_en <= 1'b0;
          end else if (warm_cnt == WU_LAST) begin
            state <= COLLECT;
          end else begin
            warm_cnt <= warm_cnt + WU_W'(1);
          end
        end

        COLLECT: begin
          if (!enable || fail_trip) begin
            state   <= enable ? FAIL : IDLE;
            trng_en <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
          end else if (word_done) begin
            if (can_load) begin
              data_q  <= shift;
              valid_q <= 1'b1;
              if (vn_emit) begin
                shift   <= {shift[WORD_WIDTH-2:0], vn_bit};
                bit_cnt <= CNT_W'(1);
              end else begin
                bit_cnt <= '0;
              end
            end else begin
              state <= FULL;
            end
          end else if (vn_emit) begin
            shift   <= {shift[WORD_WIDTH-2:0], vn_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        FULL: begin
          if (!enable) begin
            state   <= IDLE;
            trng_en <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
          end else if (accept) begin
            data_q  <= shift;
            valid_q <= 1'b1;
            bit_cnt <= '0;
            state   <= COLLECT;
          end
        end

`ifdef TRNG_HEALTH_EN
        FAIL: begin
          if (clear_fail) begin
            state <= IDLE;
          end
        end
`endif

        default: begin
          state   <= IDLE;
          trng_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: timing, conditioning, backpressure, enable drop, health test, reset.
module tb_trng_collector;

  logic clk = 1'b0;
  logic rst, enable, trng_en, trng_bit, health_fail, clear_fail;

  trng_collector_if #(.WORD_WIDTH(32)) bus ();

  trng_collector #(
    .WORD_WIDTH    (32),
    .WARMUP_CYCLES (16),
    .RCT_CUTOFF    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .trng_en     (trng_en),
    .trng_bit    (trng_bit),
    .rng         (bus),
    .health_fail (health_fail),
    .clear_fail  (clear_fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] pat_a, pat_b;
  int plen;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raw bit sampled at edge k after the enable edge; collection begins at edge 17.
  function automatic logic src_bit(input int k);
    int j;
    logic [3:0] p;
    if (k < 17) return k[0];
    j = k - 17;
    p = (j < 64) ? pat_a : pat_b;
    return p[plen - 1 - (j % plen)];
  endfunction

  task automatic step(input int k);
    trng_bit = src_bit(k);
    tick();
  endtask

  task automatic run_first(input int from_k, input int to_k, output int first_k, output logic [31:0] first_data);
    first_k = -1;
    first_data = '0;
    for (int k = from_k; k <= to_k; k++) begin
      step(k);
      if (bus.valid === 1'b1 && first_k < 0) begin
        first_k = k;
        first_data = bus.data;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; bus.ready = 1'b0; trng_bit = 1'b0; clear_fail = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (trng_en !== 1'b0) begin errors++; $display("FAIL reset_trng_en got %b want 0", trng_en); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", bus.data); end
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health got %b want 0", health_fail); end
  endtask

  task automatic test_ones();
    int fk; logic [31:0] fd;
    do_reset();
    pat_a = 4'b0010; pat_b = 4'b0010; plen = 2;
    bus.ready = 1'b1;
    start();
    checks++; if (trng_en !== 1'b1) begin errors++; $display("FAIL ones_trng_en got %b want 1", trng_en); end
    run_first(1, 81, fk, fd);
    checks++; if (fk !== 81) begin errors++; $display("FAIL ones_latency got %0d want 81", fk); end
    checks++; if (fd !== 32'hFFFFFFFF) begin errors++; $display("FAIL ones_data got %h want ffffffff", fd); end
    step(82);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ones_valid_drop got %b want 0", bus.valid); end
  endtask

  task automatic test_zeros();
    int fk; logic [31:0] fd;
    do_reset();
    pat_a = 4'b0001; pat_b = 4'b0001; plen = 2;
    bus.ready = 1'b1;
    start();
    run_first(1, 90, fk, fd);
    checks++; if (fk !== 81) begin errors++; $display("FAIL zeros_latency got %0d want 81", fk); end
    checks++; if (fd !== 32'h00000000) begin errors++; $display("FAIL zeros_data got %h want 00000000", fd); end
  endtask

  task automatic test_no_emit();
    int highs;
    do_reset();
    pat_a = 4'b0011; pat_b = 4'b0011; plen = 4;
    bus.ready = 1'b1;
    start();
    highs = 0;
    for (int k = 1; k <= 200; k++) begin
      step(k);
      if (bus.valid === 1'b1) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL no_emit_valid_cycles got %0d want 0", highs); end
  endtask

  task automatic test_backpressure();
    int fk, changes; logic [31:0] fd;
    do_reset();
    pat_a = 4'b1001; pat_b = 4'b0110; plen = 4;
    start();
    run_first(1, 81, fk, fd);
    checks++; if (fk !== 81) begin errors++; $display("FAIL bp_latency got %0d want 81", fk); end
    checks++; if (fd !== 32'hAAAAAAAA) begin errors++; $display("FAIL bp_word1 got %h want aaaaaaaa", fd); end
    changes = 0;
    for (int k = 82; k <= 150; k++) begin
      step(k);
      if (bus.valid !== 1'b1 || bus.data !== 32'hAAAAAAAA) changes++;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL bp_hold_cycles got %0d want 0", changes); end
    bus.ready = 1'b1;
    step(151);
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid_cont got %b want 1", bus.valid); end
    checks++; if (bus.data !== 32'h55555555) begin errors++; $display("FAIL bp_word2 got %h want 55555555", bus.data); end
    step(152);
    checks++; if (bus.valid !== 1'b1 || bus.data !== 32'h55555555) begin
      errors++; $display("FAIL bp_word2_hold got %b/%h want 1/55555555", bus.valid, bus.data);
    end
  endtask

  task automatic test_enable_drop();
    int fk; logic [31:0] fd;
    do_reset();
    pat_a = 4'b0010; pat_b = 4'b0010; plen = 2;
    start();
    run_first(1, 120, fk, fd);
    enable = 1'b0;
    step(121);
    checks++; if (trng_en !== 1'b0) begin errors++; $display("FAIL drop_trng_en got %b want 0", trng_en); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL drop_valid got %b want 1", bus.valid); end
    checks++; if (bus.data !== 32'hFFFFFFFF) begin errors++; $display("FAIL drop_data got %h want ffffffff", bus.data); end
    step(122);
    step(123);
    pat_a = 4'b0001; pat_b = 4'b0001;
    bus.ready = 1'b1;
    start();
    checks++; if (trng_en !== 1'b1) begin errors++; $display("FAIL reen_trng_en got %b want 1", trng_en); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reen_accept got %b want 0", bus.valid); end
    run_first(1, 90, fk, fd);
    checks++; if (fk !== 81) begin errors++; $display("FAIL reen_latency got %0d want 81", fk); end
    checks++; if (fd !== 32'h00000000) begin errors++; $display("FAIL reen_data got %h want 00000000", fd); end
  endtask

`ifdef TRNG_HEALTH_EN
  task automatic test_health();
    do_reset();
    start();
    trng_bit = 1'b1;
    for (int k = 1; k <= 47; k++) tick();
    checks++; if (health_fail !== 1'b0 || trng_en !== 1'b1) begin
      errors++; $display("FAIL rct_before got %b/%b want 0/1", health_fail, trng_en);
    end
    tick();
    checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL rct_trip got %b want 1", health_fail); end
    checks++; if (trng_en !== 1'b0) begin errors++; $display("FAIL rct_trng_en got %b want 0", trng_en); end
    for (int k = 0; k < 5; k++) tick();
    checks++; if (health_fail !== 1'b1 || trng_en !== 1'b0) begin
      errors++; $display("FAIL rct_hold got %b/%b want 1/0", health_fail, trng_en);
    end
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    checks++; if (health_fail !== 1'b0 || trng_en !== 1'b0) begin
      errors++; $display("FAIL rct_clear got %b/%b want 0/0", health_fail, trng_en);
    end
    tick();
    checks++; if (trng_en !== 1'b1) begin errors++; $display("FAIL rct_restart got %b want 1", trng_en); end
  endtask
`else
  task automatic test_health();
    do_reset();
    start();
    trng_bit = 1'b1;
    for (int k = 1; k <= 60; k++) tick();
    checks++; if (health_fail !== 1'b0 || trng_en !== 1'b1) begin
      errors++; $display("FAIL rct_off got %b/%b want 0/1", health_fail, trng_en);
    end
  endtask
`endif

  task automatic test_reset_full();
    int fk; logic [31:0] fd;
    do_reset();
    pat_a = 4'b0010; pat_b = 4'b0010; plen = 2;
    start();
    run_first(1, 150, fk, fd);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL full_pre_valid got %b want 1", bus.valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    checks++; if (bus.data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 00000000", bus.data); end
    checks++; if (trng_en !== 1'b0) begin errors++; $display("FAIL rst_trng_en got %b want 0", trng_en); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zeros();
    test_no_emit();
    test_backpressure();
    test_enable_drop();
    test_health();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumer stage directly downstream of the ring-oscillator TRNG macros.
- Drives their `trng_en` and takes the raw sampled bit.
- Removes bias with a von Neumann corrector and packs the corrected bits into words.
- Presents each word on a valid/ready interface to the bus-side register/FIFO.

Parameters:
- WORD_WIDTH, 32, bits per output word (power of two, 8..64).
- WARMUP_CYCLES, 16, raw samples discarded after enable before collection starts (>=1).
- RCT_CUTOFF, 32, consecutive identical raw bits that trip the repetition-count health test (>=2, only used with TRNG_HEALTH_EN).

Ports:
- clk  input  1  system clock; same clock that samples the TRNG.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  software enable for collection.
- trng_en  output  1  enable to all TRNG ring oscillators.
- trng_bit  input  1  raw TRNG output, already registered in the clk domain.
- data  output  WORD_WIDTH  conditioned random word.
- valid  output  1  data holds an unread word.
- ready  input  1  consumer accepts data when valid && ready.
- health_fail  output  1  sticky health-test failure flag.
- clear_fail  input  1  clears health_fail and the FAIL state.

Behaviour:
- Reset: state IDLE; trng_en=0; data=0; valid=0; health_fail=0. Shift register, bit counter, warmup counter, pair phase and repetition counter all cleared.
- trng_en=1 in WARMUP, COLLECT and FULL; trng_en=0 in IDLE and FAIL (registered output, state-decoded).
- IDLE -> WARMUP when enable=1; warmup counter loads 0.
- WARMUP:
  - Counts one per cycle and ignores trng_bit.
  - After WARMUP_CYCLES cycles -> COLLECT with pair phase 0.
- COLLECT, pairing:
  - Phase 0 captures b0 and goes to phase 1.
  - Phase 1 evaluates (b0, trng_bit) and returns to phase 0.
  - 01 emits 0, 10 emits 1, 00 and 11 emit nothing.
- COLLECT, packing:
  - An emitted bit shifts into the LSB (shift left); the bit counter increments.
  - The first emitted bit ends up at data[WORD_WIDTH-1].
  - When the counter reaches WORD_WIDTH, the word completes.
- Word completion:
  - If valid=0, or valid&&ready in the same cycle, the word loads into data the next cycle with valid=1. The counter clears and collection continues without a gap.
  - Otherwise -> FULL.
- FULL:
  - Sampling paused; shift register held.
  - On the cycle valid&&ready is seen, the word transfers (valid stays 1, new data) -> COLLECT with pair phase 0.
- Handshake:
  - data stays stable while valid=1 && ready=0.
  - valid drops the cycle after acceptance unless a new word loads in that same cycle.
  - Latency from the last contributing raw bit to valid=1 is 1 cycle.
- enable=0 in any state except FAIL:
  - -> IDLE next cycle.
  - Partial word, pair phase and counters are discarded.
  - A word already in data stays valid until read.
- enable re-asserted: always restarts WARMUP.
- rst mid-operation: returns all state to reset values, including an unread word.
- Bit counter width is clog2(WORD_WIDTH)+1. No wrap: cleared on every transfer.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- Defined:
  - The repetition counter tracks consecutive equal raw trng_bit values in COLLECT; it resets to 1 on any change and on COLLECT entry.
  - When the count reaches RCT_CUTOFF: health_fail=1 next cycle, partial word discarded, state -> FAIL.
  - FAIL holds trng_en=0 regardless of enable. An already-valid word stays readable.
  - clear_fail=1 clears health_fail and goes to IDLE. clear_fail has priority over a simultaneous new failure.
- Not defined: health_fail tied 0, clear_fail ignored, no FAIL state, no repetition counter logic.

Decomposition:
- Package trng_pkg:
  - state enum (IDLE, WARMUP, COLLECT, FULL, FAIL);
  - von Neumann pair-code constants;
  - a function computing counter widths.
- One natural sub-module: trng_vn_corrector, containing the pair phase, b0 register and emit/bit outputs. The collector owns the FSM, packing, handshake and health test.

Test Plan:
- rst, then enable=1, ready=1, trng_bit alternating 1,0 each cycle:
  - trng_en=1 from the cycle after enable;
  - first valid appears 16+64+1 cycles after WARMUP entry;
  - data=32'hFFFFFFFF (every pair is 10).
- Pattern 0,1 repeated with ready=1 -> data=32'h00000000. Pattern 00,11 repeated -> valid never asserts.
- Backpressure: ready=0, two words' worth of 10/01 pairs:
  - first word held stable;
  - FULL reached;
  - ready pulse -> second word appears the next cycle with valid continuously 1.
- enable dropped after 20 emitted bits with an unread word pending: IDLE, trng_en=0, pending word still valid; re-enable restarts the warmup of 16.
- TRNG_HEALTH_EN with trng_bit stuck at 1 for 32 cycles in COLLECT: health_fail=1, trng_en=0, FAIL held despite enable=1; clear_fail -> IDLE.
- rst asserted while valid=1 and in FULL: next cycle valid=0, data=0, trng_en=0.
